hdmi_cfg_sequencer: RTL and testbench
=====================================

Name: hdmi_cfg_sequencer

Overview:
- Avalon-MM master that programs the HDMI sync/pattern generator's control slave after a single start pulse.
- Sequence: disable gamma, load the 256-entry gamma LUT from a selectable built-in curve, optionally load the 16-row character bitmap from an external row source, then apply mode and gamma-enable.
- The final mode/gamma writes are aligned to a vertical-sync rising edge, so pattern changes never tear mid-frame.
- Sits between the system CPU/config logic and the generator's control port, in the 74.25 MHz pixel clock domain.

Parameters:
- FRAME_SYNC, 1: 1 = wait for a vsync rising edge before the final two writes; 0 = skip the wait.
- VS_TIMEOUT, 2000000: cycles to wait in WAIT_VS before forcing the final writes (>1 frame of 1,237,500 cycles).

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- cfg_mode  in  3  pattern mode; latched on accepted start.
- cfg_gamma_en  in  1  gamma enable value for the final write; latched on start.
- cfg_lut_sel  in  2  LUT curve; latched on start.
- cfg_bmp_en  in  1  1 = load bitmap rows; latched on start.
- bmp_row_idx  out  4  row index requested from the external bitmap source.
- bmp_row_data  in  16  row bits; combinational response to bmp_row_idx, zero latency.
- vsync  in  1  hdmi_vs from the generator.
- avm_address  out  3  slave register address.
- avm_write  out  1  write strobe.
- avm_writedata  out  32  write data.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle pulse at sequence end.
- vs_timeout  out  1  sticky flag: last sequence timed out in WAIT_VS; cleared on the next accepted start.

Behaviour:
- Reset values: all outputs 0; state = IDLE; all counters 0.
- Avalon handshake:
  - A write completes on a cycle where avm_write = 1 and avm_waitrequest = 0.
  - While stalled, avm_address and avm_writedata are held stable.
  - avm_write is deasserted only in IDLE, WAIT_VS and DONE.
  - Back-to-back writes are allowed: one write per cycle when waitrequest is low.
- FSM sequence, IDLE -> GOFF -> LUT_A -> LUT_D -> (BMP_A -> BMP_D) -> WAIT_VS -> SET_MODE -> SET_GAMMA -> DONE -> IDLE:
  - IDLE: on start = 1, latch cfg_*, clear vs_timeout, clear counters, go to GOFF. avm_write is asserted in the next cycle.
  - GOFF: write addr 1, data 0.
  - LUT_A: write addr 2, data {24'd0, i}.
  - LUT_D: write addr 3, data {24'd0, f(i)}. On completion with i = 255, go to BMP_A if cfg_bmp_en, else WAIT_VS; otherwise i++ and return to LUT_A.
  - BMP_A: write addr 4, data {28'd0, r}.
  - BMP_D: write addr 5, data {16'd0, bmp_row_data}, with bmp_row_idx = r. After r = 15, go to WAIT_VS.
  - WAIT_VS:
    - avm_write = 0.
    - Exits on the first vsync rising edge detected while in this state, where edge = vsync & ~vsync_d and vsync_d is a register.
    - An edge that occurred before entry does not count.
    - If FRAME_SYNC = 0, exit after one cycle.
    - If the timeout counter reaches VS_TIMEOUT-1, set vs_timeout and exit.
  - SET_MODE: write addr 0, data {29'd0, mode}.
  - SET_GAMMA: write addr 1, data {31'd0, gamma_en}.
  - DONE: done = 1 for one cycle, busy = 0, go to IDLE.
- LUT curve f(i), 8-bit:
  - sel 0: i.
  - sel 1: 255 - i.
  - sel 2: {i[7:6], 6'd0}.
  - sel 3: (i*i) >> 8, using a 16-bit product and taking bits [15:8].
- Write count with no stalls: 1 + 512 + (32 if bmp) + 2. The first write is in cycle 1 after start.
- start while busy: ignored, with no latch and no effect on the in-flight sequence.
- Reset mid-sequence: immediate return to IDLE with all outputs 0. A partially loaded LUT is left in the slave; gamma remains disabled, because GOFF has already executed.
- bmp_row_idx: holds r in BMP_A/BMP_D and is 0 otherwise.

Test Plan:
- sel=0, bmp_en=0, mode=3, gamma=1, FRAME_SYNC=0, waitrequest=0 -> exactly 515 writes; first write (1, 0); LUT pairs (2, i), (3, i) for i = 0..255; last writes (0, 3), (1, 1); done pulses once; busy is high for 516 cycles.
- sel=3 -> data written for i = 128 is 64, for i = 255 is 254, for i = 16 is 1; sel=1, i = 0 -> 255; sel=2, i = 0xBF -> 0x80.
- waitrequest high for 3 cycles on the 10th write -> address and data held constant for those 4 cycles; no write duplicated or skipped; total completed writes unchanged.
- bmp_en=1, source returns 16'hA5A0 + r -> writes (4, r), (5, 0xA5A0 + r) for r = 0..15, placed between the LUT writes and WAIT_VS.
- FRAME_SYNC=1, vsync already high at WAIT_VS entry -> no exit until the next low-to-high transition. vsync held low, VS_TIMEOUT=100 -> vs_timeout = 1 and final writes issued 100 cycles after entry.
- start pulsed mid-LUT load -> ignored. reset_n asserted mid-LUT -> all outputs 0 asynchronously. A new start after release -> full sequence restarts from GOFF.

Source files
------------

// File: rtl/hdmi_cfg_sequencer.sv
// Avalon-MM master that programs the HDMI generator control slave after a start pulse:
// gamma off, gamma LUT load, optional bitmap load, then vsync-aligned mode and gamma-enable writes.
module hdmi_cfg_sequencer #(
  parameter bit          FRAME_SYNC = 1'b1,
  parameter int unsigned VS_TIMEOUT = 2000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  cfg_mode,
  input  logic        cfg_gamma_en,
  input  logic [1:0]  cfg_lut_sel,
  input  logic        cfg_bmp_en,
  output logic [3:0]  bmp_row_idx,
  input  logic [15:0] bmp_row_data,
  input  logic        vsync,
  output logic [2:0]  avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        vs_timeout
);

  localparam int unsigned TMO_W = (VS_TIMEOUT > 1) ? $clog2(VS_TIMEOUT) : 1;

  localparam logic [2:0] A_MODE  = 3'd0;
  localparam logic [2:0] A_GAMMA = 3'd1;
  localparam logic [2:0] A_LUT_A = 3'd2;
  localparam logic [2:0] A_LUT_D = 3'd3;
  localparam logic [2:0] A_BMP_A = 3'd4;
  localparam logic [2:0] A_BMP_D = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_GOFF, S_LUT_A, S_LUT_D, S_BMP_A, S_BMP_D,
    S_WAIT_VS, S_SET_MODE, S_SET_GAMMA, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [7:0]         lut_idx, lut_nxt;
  logic [3:0]         row_idx, row_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
  logic               vsync_d;
  logic [2:0]         mode_q;
  logic               gamma_q;
  logic [1:0]         sel_q;
  logic               bmp_q;

  logic               accept, tmo_hit, wr_done, vs_edge;
  logic [2:0]         addr_nxt;
  logic [31:0]        data_nxt;
  logic               write_nxt, busy_nxt, done_nxt;
  logic [3:0]         idx_nxt;

  // Built-in gamma curves, indexed by LUT position.
  function automatic logic [7:0] lut_curve(input logic [1:0] sel, input logic [7:0] i);
    case (sel)
      2'd0:    return i;
      2'd1:    return 8'd255 - i;
      2'd2:    return {i[7:6], 6'd0};
      default: return 8'((16'(i) * 16'(i)) >> 8);
    endcase
  endfunction

  assign wr_done = avm_write & ~avm_waitrequest;
  assign vs_edge = vsync & ~vsync_d;

  always_comb begin
    state_nxt = state;
    lut_nxt   = lut_idx;
    row_nxt   = row_idx;
    tmo_nxt   = '0;
    accept    = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_nxt = S_GOFF;
        lut_nxt   = '0;
        row_nxt   = '0;
        accept    = 1'b1;
      end
      S_GOFF:  if (wr_done) state_nxt = S_LUT_A;
      S_LUT_A: if (wr_done) state_nxt = S_LUT_D;
      S_LUT_D: if (wr_done) begin
        if (lut_idx == 8'hFF) begin
          state_nxt = bmp_q ? S_BMP_A : S_WAIT_VS;
        end else begin
          lut_nxt   = lut_idx + 8'd1;
          state_nxt = S_LUT_A;
        end
      end
      S_BMP_A: if (wr_done) state_nxt = S_BMP_D;
      S_BMP_D: if (wr_done) begin
        if (row_idx == 4'hF) begin
          state_nxt = S_WAIT_VS;
        end else begin
          row_nxt   = row_idx + 4'd1;
          state_nxt = S_BMP_A;
        end
      end
      // A vsync edge wins over a coincident timeout, so the flag only marks a genuine miss.
      S_WAIT_VS: begin
        if (!FRAME_SYNC || vs_edge) begin
          state_nxt = S_SET_MODE;
        end else if (tmo_cnt == TMO_W'(VS_TIMEOUT - 1)) begin
          state_nxt = S_SET_MODE;
          tmo_hit   = 1'b1;
        end else begin
          tmo_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      S_SET_MODE:  if (wr_done) state_nxt = S_SET_GAMMA;
      S_SET_GAMMA: if (wr_done) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase

    // Bus outputs are registered from the upcoming state, so they are stable while stalled.
    addr_nxt  = '0;
    data_nxt  = '0;
    write_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    idx_nxt   = '0;
    case (state_nxt)
      S_GOFF: begin
        write_nxt = 1'b1; busy_nxt = 1'b1; addr_nxt = A_GAMMA;
      end
      S_LUT_A: begin
        write_nxt = 1'b1; busy_nxt = 1'b1; addr_nxt = A_LUT_A;
        data_nxt  = {24'd0, lut_nxt};
      end
      S_LUT_D: begin
        write_nxt = 1'b1; busy_nxt = 1'b1; addr_nxt = A_LUT_D;
        data_nxt  = {24'd0, lut_curve(sel_q, lut_nxt)};
      end
      S_BMP_A: begin
        write_nxt = 1'b1; busy_nxt = 1'b1; addr_nxt = A_BMP_A;
        data_nxt  = {28'd0, row_nxt};
        idx_nxt   = row_nxt;
      end
      // bmp_row_idx already equals row_nxt here, so bmp_row_data is the requested row.
      S_BMP_D: begin
        write_nxt = 1'b1; busy_nxt = 1'b1; addr_nxt = A_BMP_D;
        data_nxt  = {16'd0, bmp_row_data};
        idx_nxt   = row_nxt;
      end
      S_WAIT_VS: busy_nxt = 1'b1;
      S_SET_MODE: begin
        write_nxt = 1'b1; busy_nxt = 1'b1; addr_nxt = A_MODE;
        data_nxt  = {29'd0, mode_q};
      end
      S_SET_GAMMA: begin
        write_nxt = 1'b1; busy_nxt = 1'b1; addr_nxt = A_GAMMA;
        data_nxt  = {31'd0, gamma_q};
      end
      S_DONE:  done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      lut_idx       <= '0;
      row_idx       <= '0;
      tmo_cnt       <= '0;
      vsync_d       <= 1'b0;
      mode_q        <= '0;
      gamma_q       <= 1'b0;
      sel_q         <= '0;
      bmp_q         <= 1'b0;
      vs_timeout    <= 1'b0;
      avm_address   <= '0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bmp_row_idx   <= '0;
    end else begin
      state         <= state_nxt;
      lut_idx       <= lut_nxt;
      row_idx       <= row_nxt;
      tmo_cnt       <= tmo_nxt;
      vsync_d       <= vsync;
      if (accept) begin
        mode_q  <= cfg_mode;
        gamma_q <= cfg_gamma_en;
        sel_q   <= cfg_lut_sel;
        bmp_q   <= cfg_bmp_en;
      end
      if (accept)       vs_timeout <= 1'b0;
      else if (tmo_hit) vs_timeout <= 1'b1;
      avm_address   <= addr_nxt;
      avm_write     <= write_nxt;
      avm_writedata <= data_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      bmp_row_idx   <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Bench for hdmi_cfg_sequencer: one free-running instance (no frame sync) and one
// frame-synced instance with a short timeout, checked against a write-list model.
module tb_hdmi_cfg_sequencer;

  localparam int unsigned TMO = 100;

  typedef struct { logic [2:0] a; logic [31:0] d; int cyc; } wr_t;
  typedef struct { int sel; int i; int f; } lut_vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  cfg_mode;
  logic        cfg_gamma_en;
  logic [1:0]  cfg_lut_sel;
  logic        cfg_bmp_en;
  logic        vsync;
  logic        waitrequest;
  logic [15:0] bmp_key;
  logic        start [2];
  logic [3:0]  row_idx [2];
  logic [15:0] row_data [2];
  logic [2:0]  addr [2];
  logic        wr [2];
  logic [31:0] wd [2];
  logic        busy [2];
  logic        done [2];
  logic        vto [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign row_data[0] = bmp_key + 16'(row_idx[0]);
  assign row_data[1] = bmp_key + 16'(row_idx[1]);

  hdmi_cfg_sequencer #(.FRAME_SYNC(1'b0), .VS_TIMEOUT(TMO)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]),
    .cfg_mode(cfg_mode), .cfg_gamma_en(cfg_gamma_en), .cfg_lut_sel(cfg_lut_sel), .cfg_bmp_en(cfg_bmp_en),
    .bmp_row_idx(row_idx[0]), .bmp_row_data(row_data[0]), .vsync(vsync),
    .avm_address(addr[0]), .avm_write(wr[0]), .avm_writedata(wd[0]), .avm_waitrequest(waitrequest),
    .busy(busy[0]), .done(done[0]), .vs_timeout(vto[0])
  );

  hdmi_cfg_sequencer #(.FRAME_SYNC(1'b1), .VS_TIMEOUT(TMO)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]),
    .cfg_mode(cfg_mode), .cfg_gamma_en(cfg_gamma_en), .cfg_lut_sel(cfg_lut_sel), .cfg_bmp_en(cfg_bmp_en),
    .bmp_row_idx(row_idx[1]), .bmp_row_data(row_data[1]), .vsync(vsync),
    .avm_address(addr[1]), .avm_write(wr[1]), .avm_writedata(wd[1]), .avm_waitrequest(waitrequest),
    .busy(busy[1]), .done(done[1]), .vs_timeout(vto[1])
  );

  // Monitor: completed writes, busy/done cycles, and address/data stability across stalls.
  wr_t         q0[$];
  wr_t         q1[$];
  int          bc [2] = '{0, 0};
  int          dc [2] = '{0, 0};
  int          hchk [2] = '{0, 0};
  int          hbad [2] = '{0, 0};
  logic        hpend [2] = '{1'b0, 1'b0};
  logic [2:0]  ha [2];
  logic [31:0] hd [2];

  always @(negedge clk) begin
    wr_t w;
    for (int k = 0; k < 2; k++) begin
      if (reset_n === 1'b1) begin
        if (hpend[k]) begin
          hchk[k]++;
          if (!(wr[k] === 1'b1 && addr[k] === ha[k] && wd[k] === hd[k])) hbad[k]++;
        end
        hpend[k] = (wr[k] === 1'b1) && (waitrequest === 1'b1);
        ha[k] = addr[k];
        hd[k] = wd[k];
        if (wr[k] === 1'b1 && waitrequest === 1'b0) begin
          w.a = addr[k]; w.d = wd[k]; w.cyc = cyc;
          if (k == 0) q0.push_back(w); else q1.push_back(w);
        end
        if (busy[k] === 1'b1) bc[k]++;
        if (done[k] === 1'b1) dc[k]++;
      end else begin
        hpend[k] = 1'b0;
      end
    end
  end

  int b_q, b_bc, b_dc, b_hc, b_hb, s_cyc;
  int stall_mode = 0;
  int stalls_done = 0;

  // Slave stall model: none, random, or three cycles on the 10th write of dut0.
  always @(posedge clk) begin
    #1;
    if (stall_mode == 1) waitrequest = ($urandom_range(0, 3) == 0);
    else if (stall_mode == 2 && q0.size() - b_q == 9 && wr[0] === 1'b1 && stalls_done < 3) begin
      waitrequest = 1'b1;
      stalls_done++;
    end else waitrequest = 1'b0;
    if (stall_mode != 2) stalls_done = 0;
  end

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic wr_t qget(input int k, input int i);
    return (k == 0) ? q0[i] : q1[i];
  endfunction

  function automatic int f_ref(input int sel, input int i);
    case (sel)
      0:       return i;
      1:       return 255 - i;
      2:       return (i / 64) * 64;
      default: return (i * i) / 256;
    endcase
  endfunction

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference write list: gamma off, LUT pairs, optional bitmap pairs, mode, gamma enable.
  wr_t exp_q[$];
  task automatic build_exp(input int sel, input int bmp, input int mode, input int gamma, input logic [15:0] key);
    wr_t e;
    e.cyc = 0;
    exp_q.delete();
    e.a = 3'd1; e.d = 32'd0; exp_q.push_back(e);
    for (int i = 0; i < 256; i++) begin
      e.a = 3'd2; e.d = 32'(i);            exp_q.push_back(e);
      e.a = 3'd3; e.d = 32'(f_ref(sel, i)); exp_q.push_back(e);
    end
    if (bmp != 0) begin
      for (int r = 0; r < 16; r++) begin
        e.a = 3'd4; e.d = 32'(r);                   exp_q.push_back(e);
        e.a = 3'd5; e.d = 32'(16'(32'(key) + r));   exp_q.push_back(e);
      end
    end
    e.a = 3'd0; e.d = 32'(mode);  exp_q.push_back(e);
    e.a = 3'd1; e.d = 32'(gamma); exp_q.push_back(e);
  endtask

  task automatic check_list(input int k, input string name);
    int n; int bad; wr_t w; longint act; longint expv;
    n = qsize(k) - b_q;
    chk(n == exp_q.size(), {name, "_count"}, n, exp_q.size());
    bad = -1; act = 0; expv = 0;
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      w = qget(k, b_q + i);
      if (bad < 0 && (w.a !== exp_q[i].a || w.d !== exp_q[i].d)) begin
        bad = i; act = {w.a, w.d}; expv = {exp_q[i].a, exp_q[i].d};
      end
    end
    chk(bad < 0, $sformatf("%s_write%0d(addr,data)", name, bad), act, expv);
  endtask

  task automatic check_zero(input int k, input string name);
    logic [42:0] v;
    v = {addr[k], wr[k], wd[k], busy[k], done[k], vto[k], row_idx[k]};
    chk(v === '0, name, v, 0);
  endtask

  task automatic start_seq(input int k, input int sel, input int bmp, input int mode, input int gamma);
    @(posedge clk); #1;
    b_q = qsize(k); b_bc = bc[k]; b_dc = dc[k]; b_hc = hchk[k]; b_hb = hbad[k];
    cfg_lut_sel = 2'(sel); cfg_bmp_en = 1'(bmp); cfg_mode = 3'(mode); cfg_gamma_en = 1'(gamma);
    start[k] = 1'b1; s_cyc = cyc;
    @(posedge clk); #1;
    start[k] = 1'b0;
  endtask

  task automatic wait_writes(input int k, input int nw, input int budget, input string name);
    int n = 0;
    while (qsize(k) - b_q < nw && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk(qsize(k) - b_q >= nw, name, qsize(k) - b_q, nw);
  endtask

  // Waits for done; optionally pulses start with scrambled cfg once poke_at writes are in.
  task automatic wait_done(input int k, input int budget, input int poke_at);
    int n = 0;
    bit poked = 1'b0;
    while (dc[k] == b_dc && n < budget) begin
      @(posedge clk); #1; n++;
      start[k] = 1'b0;
      if (poke_at >= 0 && !poked && qsize(k) - b_q >= poke_at) begin
        cfg_mode = 3'($urandom); cfg_lut_sel = 2'($urandom);
        cfg_bmp_en = 1'($urandom); cfg_gamma_en = 1'($urandom);
        start[k] = 1'b1; poked = 1'b1;
      end
    end
    start[k] = 1'b0;
    chk(dc[k] != b_dc, "done_seen", dc[k] - b_dc, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run(input int k, input int sel, input int bmp, input int mode, input int gamma,
                     input logic [15:0] key, input int poke_at, input string name);
    bmp_key = key;
    start_seq(k, sel, bmp, mode, gamma);
    wait_done(k, 8000, poke_at);
    build_exp(sel, bmp, mode, gamma, key);
    check_list(k, name);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    lut_vec_t    tbl [6];
    wr_t         w;
    int          t_edge;
    logic [15:0] key;

    tbl[0] = '{3, 128, 64};
    tbl[1] = '{3, 255, 254};
    tbl[2] = '{3, 16, 1};
    tbl[3] = '{1, 0, 255};
    tbl[4] = '{2, 8'hBF, 8'h80};
    tbl[5] = '{0, 77, 77};

    reset_n = 1'b0; vsync = 1'b0; bmp_key = 16'hA5A0;
    cfg_mode = '0; cfg_gamma_en = 1'b0; cfg_lut_sel = '0; cfg_bmp_en = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero(0, "reset_outputs0");
    check_zero(1, "reset_outputs1");
    reset_n = 1'b1;

    // Basic sequence: identity curve, no bitmap, no stalls.
    run(0, 0, 0, 3, 1, 16'hA5A0, -1, "basic");
    chk(qget(0, b_q).cyc == s_cyc + 1, "first_write_latency", qget(0, b_q).cyc - s_cyc, 1);
    chk(bc[0] - b_bc == 516, "busy_cycles", bc[0] - b_bc, 516);
    chk(dc[0] - b_dc == 1, "done_pulses", dc[0] - b_dc, 1);
    chk(busy[0] === 1'b0, "busy_after_done", busy[0], 0);

    // LUT curve spot values.
    for (int t = 0; t < 6; t++) begin
      run(0, tbl[t].sel, 0, 1, 0, 16'hA5A0, -1, $sformatf("lut_sel%0d", tbl[t].sel));
      w = qget(0, b_q + 1 + 2 * tbl[t].i);
      chk(w.a === 3'd2 && w.d === 32'(tbl[t].i), $sformatf("lut_index_sel%0d_i%0d", tbl[t].sel, tbl[t].i),
          {w.a, w.d}, {3'd2, 32'(tbl[t].i)});
      w = qget(0, b_q + 2 + 2 * tbl[t].i);
      chk(w.a === 3'd3 && w.d === 32'(tbl[t].f), $sformatf("lut_value_sel%0d_i%0d", tbl[t].sel, tbl[t].i),
          {w.a, w.d}, {3'd3, 32'(tbl[t].f)});
    end

    // Three-cycle stall on the 10th write.
    stall_mode = 2;
    run(0, 0, 0, 5, 0, 16'hA5A0, -1, "stall10");
    chk(stalls_done == 3, "stall_cycles_applied", stalls_done, 3);
    stall_mode = 0;
    chk(hchk[0] - b_hc == 3, "stall_hold_count", hchk[0] - b_hc, 3);
    chk(hbad[0] - b_hb == 0, "stall_hold_stable", hbad[0] - b_hb, 0);

    // Bitmap load.
    run(0, 2, 1, 6, 1, 16'hA5A0, -1, "bitmap");
    chk(bc[0] - b_bc == 548, "busy_cycles_bmp", bc[0] - b_bc, 548);

    // Randomized configurations under random stalls; first one also gets a mid-LUT start pulse.
    stall_mode = 1;
    for (int it = 0; it < 5; it++) begin
      key = 16'($urandom);
      run(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 1)), key, (it == 0) ? 100 : -1, $sformatf("random%0d", it));
      chk(hbad[0] - b_hb == 0, $sformatf("random%0d_hold_stable", it), hbad[0] - b_hb, 0);
    end
    stall_mode = 0;
    @(posedge clk); #1;

    // Frame sync with vsync held low: timeout path.
    vsync = 1'b0;
    run(1, 1, 0, 2, 1, 16'hA5A0, -1, "vs_timeout");
    chk(vto[1] === 1'b1, "vs_timeout_flag", vto[1], 1);
    chk(qget(1, b_q + 513).cyc - qget(1, b_q + 512).cyc == TMO + 1, "timeout_latency",
        qget(1, b_q + 513).cyc - qget(1, b_q + 512).cyc, TMO + 1);

    // Frame sync with vsync already high at entry: only a fresh rising edge releases.
    vsync = 1'b1;
    bmp_key = 16'hA5A0;
    start_seq(1, 3, 0, 7, 0);
    chk(vto[1] === 1'b0, "vs_timeout_cleared", vto[1], 0);
    wait_writes(1, 513, 3000, "reach_wait_vs");
    repeat (20) @(posedge clk);
    #1;
    chk(qsize(1) - b_q == 513, "vs_high_no_exit", qsize(1) - b_q, 513);
    vsync = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    vsync = 1'b1;
    t_edge = cyc;
    wait_done(1, 1000, -1);
    build_exp(3, 0, 7, 0, 16'hA5A0);
    check_list(1, "vs_edge");
    chk(qget(1, b_q + 513).cyc == t_edge + 1, "vs_edge_latency", qget(1, b_q + 513).cyc - t_edge, 1);
    chk(vto[1] === 1'b0, "vs_edge_no_timeout", vto[1], 0);

    // Asynchronous reset mid-LUT, then a clean restart.
    start_seq(0, 1, 0, 4, 1);
    wait_writes(0, 50, 500, "reach_mid_lut");
    #2;
    reset_n = 1'b0;
    #1;
    check_zero(0, "async_reset0");
    check_zero(1, "async_reset1");
    @(posedge clk); #1;
    check_zero(0, "reset_held0");
    reset_n = 1'b1;
    run(0, 1, 0, 4, 1, 16'hA5A0, -1, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
